// File: rtl/tlb_refill.sv
// Hardware TLB refill engine: fetches the even/odd PTE pair for a missing page
// and programs the MMU through its register/command port, finishing with WRITE_TLB.
`ifndef MMU_CMD_T
`define MMU_CMD_T         logic [1:0]
`define MMU_CMD_NONE      2'd0
`define MMU_CMD_WRITE_REG 2'd1
`define MMU_CMD_WRITE_TLB 2'd2
`endif
`ifndef MMU_REG_T
`define MMU_REG_T         logic [2:0]
`define MMU_REG_INDEX     3'd0
`define MMU_REG_ENTRYHI   3'd1
`define MMU_REG_PAGEMASK  3'd2
`define MMU_REG_ENTRYLO0  3'd3
`define MMU_REG_ENTRYLO1  3'd4
`endif

module tlb_refill #(
  parameter int ENTRY_ADDR_WIDTH = 3,
  parameter int WIRED            = 0
) (
  input  logic        clk,
  input  logic        res,
  input  logic        miss_valid,
  input  logic [31:0] miss_vAddr,
  input  logic [7:0]  miss_asid,
  output logic        miss_ready,
  input  logic [31:0] ptBase,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output `MMU_CMD_T   mmu_cmd,
  output `MMU_REG_T   mmu_reg,
  output logic [31:0] mmu_dataIn,
  output logic        refill_done,
  output logic        refill_fault
);
  localparam logic [ENTRY_ADDR_WIDTH-1:0] VICTIM_FIRST = ENTRY_ADDR_WIDTH'(WIRED);
  localparam logic [ENTRY_ADDR_WIDTH-1:0] VICTIM_LAST  = {ENTRY_ADDR_WIDTH{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_RD_EVEN, S_RD_ODD, S_W_INDEX, S_W_HI,
    S_W_MASK, S_W_LO0, S_W_LO1, S_W_TLB, S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [18:0]                 vpn2_q, vpn2_d;
  logic [7:0]                  asid_q, asid_d;
  logic [31:0]                 pte_addr_q, pte_addr_d;
  logic [31:0]                 lo0_q, lo0_d;
  logic [31:0]                 lo1_q, lo1_d;
  logic                        fault_q, fault_d;
  logic [ENTRY_ADDR_WIDTH-1:0] victim_q, victim_d;
  logic                        miss_ready_q, miss_ready_d;
  logic                        mem_req_q, mem_req_d;
  logic [31:0]                 mem_addr_q, mem_addr_d;
  `MMU_CMD_T                   mmu_cmd_q, mmu_cmd_d;
  `MMU_REG_T                   mmu_reg_q, mmu_reg_d;
  logic [31:0]                 mmu_data_q, mmu_data_d;
  logic                        done_q, done_d;
  logic                        fault_out_q, fault_out_d;

  // Page offset bits never reach the TLB; the pair is selected by vpn2 alone.
  logic unused_vaddr_low;
  assign unused_vaddr_low = ^miss_vAddr[12:0];

  always_comb begin
    state_d    = state_q;
    vpn2_d     = vpn2_q;
    asid_d     = asid_q;
    pte_addr_d = pte_addr_q;
    lo0_d      = lo0_q;
    lo1_d      = lo1_q;
    fault_d    = fault_q;
    victim_d   = victim_q;
    case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          vpn2_d     = miss_vAddr[31:13];
          asid_d     = miss_asid;
          pte_addr_d = ptBase + {10'd0, miss_vAddr[31:13], 3'b000};
          fault_d    = 1'b0;
          state_d    = S_RD_EVEN;
        end
      end
      S_RD_EVEN: begin
        if (mem_ready) begin
          lo0_d   = mem_data;
          state_d = S_RD_ODD;
        end
      end
      S_RD_ODD: begin
        if (mem_ready) begin
          lo1_d = mem_data;
          if (!lo0_q[1] && !mem_data[1]) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_W_INDEX;
          end
        end
      end
      S_W_INDEX: state_d = S_W_HI;
      S_W_HI:    state_d = S_W_MASK;
      S_W_MASK:  state_d = S_W_LO0;
      S_W_LO0:   state_d = S_W_LO1;
      S_W_LO1:   state_d = S_W_TLB;
      S_W_TLB: begin
        victim_d = (victim_q == VICTIM_LAST) ? VICTIM_FIRST : victim_q + 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Outputs are the Moore decode of the next state, registered so they
    // appear together with the state they belong to.
    miss_ready_d = (state_d == S_IDLE);
    mem_req_d    = (state_d == S_RD_EVEN) || (state_d == S_RD_ODD);
    mem_addr_d   = 32'd0;
    if (state_d == S_RD_EVEN) begin
      mem_addr_d = pte_addr_d;
    end else if (state_d == S_RD_ODD) begin
      mem_addr_d = pte_addr_d + 32'd4;
    end
    mmu_cmd_d  = `MMU_CMD_NONE;
    mmu_reg_d  = `MMU_REG_INDEX;
    mmu_data_d = 32'd0;
    case (state_d)
      S_W_INDEX: begin
        mmu_cmd_d  = `MMU_CMD_WRITE_REG;
        mmu_data_d = {{(32-ENTRY_ADDR_WIDTH){1'b0}}, victim_q};
      end
      S_W_HI: begin
        mmu_cmd_d  = `MMU_CMD_WRITE_REG;
        mmu_reg_d  = `MMU_REG_ENTRYHI;
        mmu_data_d = {vpn2_q, 5'd0, asid_q};
      end
      S_W_MASK: begin
        mmu_cmd_d = `MMU_CMD_WRITE_REG;
        mmu_reg_d = `MMU_REG_PAGEMASK;
      end
      S_W_LO0: begin
        mmu_cmd_d  = `MMU_CMD_WRITE_REG;
        mmu_reg_d  = `MMU_REG_ENTRYLO0;
        mmu_data_d = lo0_q;
      end
      S_W_LO1: begin
        mmu_cmd_d  = `MMU_CMD_WRITE_REG;
        mmu_reg_d  = `MMU_REG_ENTRYLO1;
        mmu_data_d = lo1_q;
      end
      S_W_TLB:  mmu_cmd_d = `MMU_CMD_WRITE_TLB;
      default:  mmu_cmd_d = `MMU_CMD_NONE;
    endcase
    done_d      = (state_d == S_DONE);
    fault_out_d = (state_d == S_DONE) && fault_d;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= S_IDLE;
      vpn2_q       <= '0;
      asid_q       <= '0;
      pte_addr_q   <= '0;
      lo0_q        <= '0;
      lo1_q        <= '0;
      fault_q      <= 1'b0;
      victim_q     <= VICTIM_FIRST;
      miss_ready_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mmu_cmd_q    <= `MMU_CMD_NONE;
      mmu_reg_q    <= `MMU_REG_INDEX;
      mmu_data_q   <= '0;
      done_q       <= 1'b0;
      fault_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vpn2_q       <= vpn2_d;
      asid_q       <= asid_d;
      pte_addr_q   <= pte_addr_d;
      lo0_q        <= lo0_d;
      lo1_q        <= lo1_d;
      fault_q      <= fault_d;
      victim_q     <= victim_d;
      miss_ready_q <= miss_ready_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mmu_cmd_q    <= mmu_cmd_d;
      mmu_reg_q    <= mmu_reg_d;
      mmu_data_q   <= mmu_data_d;
      done_q       <= done_d;
      fault_out_q  <= fault_out_d;
    end
  end

  assign miss_ready   = miss_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mmu_cmd      = mmu_cmd_q;
  assign mmu_reg      = mmu_reg_q;
  assign mmu_dataIn   = mmu_data_q;
  assign refill_done  = done_q;
  assign refill_fault = fault_out_q;
endmodule
